// File: rtl/operand_stage_pkg.sv
// Shared datapath types and ALU operation codes for the operand stage and its register file.
package operand_stage_pkg;

    localparam int DATA_PATH_WIDTH     = 32;
    localparam int ALU_CODE_PATH_WIDTH = 4;
    localparam int REG_NUM_PATH_WIDTH  = 5;

    typedef logic [DATA_PATH_WIDTH-1:0]     DataPath;
    typedef logic [ALU_CODE_PATH_WIDTH-1:0] ALUCodePath;
    typedef logic [REG_NUM_PATH_WIDTH-1:0]  RegNumPath;

    localparam ALUCodePath ALU_CODE_ADD = 4'd0;
    localparam ALUCodePath ALU_CODE_SUB = 4'd1;
    localparam ALUCodePath ALU_CODE_AND = 4'd2;
    localparam ALUCodePath ALU_CODE_OR  = 4'd3;
    localparam ALUCodePath ALU_CODE_XOR = 4'd4;
    localparam ALUCodePath ALU_CODE_SLT = 4'd5;
    localparam ALUCodePath ALU_CODE_SLL = 4'd6;
    localparam ALUCodePath ALU_CODE_SRL = 4'd7;

    // True when a write lands on a real register and matches the given read index.
    function automatic logic write_hits(input logic we, input RegNumPath wr_num, input RegNumPath rd_num);
        return we && (wr_num != 5'd0) && (wr_num == rd_num);
    endfunction

endpackage

// File: rtl/operand_stage_register_file.sv
// 2-read/1-write register file with hardwired-zero r0.
// Same-edge write forwarding is enabled by OPERAND_STAGE_WRITE_BYPASS_EN.
module register_file
    import operand_stage_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_PATH_WIDTH,
    parameter int REG_NUM_WIDTH = REG_NUM_PATH_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REG_NUM_WIDTH-1:0] rdNumA,
    input  logic [REG_NUM_WIDTH-1:0] rdNumB,
    output logic [DATA_WIDTH-1:0]    rdDataA,
    output logic [DATA_WIDTH-1:0]    rdDataB,
    input  logic                     wrEnable,
    input  logic [REG_NUM_WIDTH-1:0] wrNum,
    input  logic [DATA_WIDTH-1:0]    wrData
);

    localparam int DEPTH = 1 << REG_NUM_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic                  w_hit_a;
    logic                  w_hit_b;

    // Register storage; r0 is never written so its reads stay zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wrEnable && (wrNum != '0)) begin
            r_regs[wrNum] <= wrData;
        end
    end

`ifdef OPERAND_STAGE_WRITE_BYPASS_EN
    assign w_hit_a = wrEnable && (wrNum != '0) && (wrNum == rdNumA);
    assign w_hit_b = wrEnable && (wrNum != '0) && (wrNum == rdNumB);
`else
    assign w_hit_a = 1'b0;
    assign w_hit_b = 1'b0;
`endif

    assign rdDataA = (rdNumA == '0) ? '0 : (w_hit_a ? wrData : r_regs[rdNumA]);
    assign rdDataB = (rdNumB == '0) ? '0 : (w_hit_b ? wrData : r_regs[rdNumB]);

endmodule

// File: rtl/operand_stage.sv
// Operand fetch stage: register-file read, immediate select and a one-entry output latch.
// Build option OPERAND_STAGE_WRITE_BYPASS_EN forwards same-edge writeback data to the reads.
module operand_stage
    import operand_stage_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_PATH_WIDTH,
    parameter int REG_NUM_WIDTH = REG_NUM_PATH_WIDTH,
    parameter int CODE_WIDTH    = ALU_CODE_PATH_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [REG_NUM_WIDTH-1:0] rsNum,
    input  logic [REG_NUM_WIDTH-1:0] rtNum,
    input  logic [REG_NUM_WIDTH-1:0] dstNum,
    input  logic [DATA_WIDTH-1:0]    imm,
    input  logic                     useImm,
    input  logic [CODE_WIDTH-1:0]    inCode,
    input  logic                     wrEnable,
    input  logic [REG_NUM_WIDTH-1:0] wrNum,
    input  logic [DATA_WIDTH-1:0]    wrData,
    output logic                     outValid,
    input  logic                     outReady,
    input  logic                     flush,
    output logic [DATA_WIDTH-1:0]    aluInA,
    output logic [DATA_WIDTH-1:0]    aluInB,
    output logic [CODE_WIDTH-1:0]    aluCode,
    output logic [REG_NUM_WIDTH-1:0] outDstNum
);

    logic                     r_valid;
    logic [DATA_WIDTH-1:0]    r_a;
    logic [DATA_WIDTH-1:0]    r_b;
    logic [CODE_WIDTH-1:0]    r_code;
    logic [REG_NUM_WIDTH-1:0] r_dst;
    logic [DATA_WIDTH-1:0]    w_rd_a;
    logic [DATA_WIDTH-1:0]    w_rd_b;
    logic                     w_accept;

    register_file #(
        .DATA_WIDTH    (DATA_WIDTH),
        .REG_NUM_WIDTH (REG_NUM_WIDTH)
    ) u_register_file (
        .clk      (clk),
        .rst      (rst),
        .rdNumA   (rsNum),
        .rdNumB   (rtNum),
        .rdDataA  (w_rd_a),
        .rdDataB  (w_rd_b),
        .wrEnable (wrEnable),
        .wrNum    (wrNum),
        .wrData   (wrData)
    );

    assign inReady  = !r_valid || outReady;
    assign w_accept = inValid && inReady && !flush;

    // Output latch: flush wins, then accept (replaces a draining entry), then drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_code  <= '0;
            r_dst   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_a     <= w_rd_a;
            r_b     <= useImm ? imm : w_rd_b;
            r_code  <= inCode;
            r_dst   <= dstNum;
        end else if (outReady) begin
            r_valid <= 1'b0;
        end
    end

    assign outValid  = r_valid;
    assign aluInA    = r_a;
    assign aluInB    = r_b;
    assign aluCode   = r_code;
    assign outDstNum = r_dst;

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: directed vector table, reset-mid-stall sequence and
// randomized traffic against a behavioural model (honours OPERAND_STAGE_WRITE_BYPASS_EN).
module tb_operand_stage;
    import operand_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid, inReady, useImm, wrEnable, outValid, outReady, flush;
    logic [4:0]  rsNum, rtNum, dstNum, wrNum, outDstNum;
    logic [31:0] imm, wrData, aluInA, aluInB;
    logic [3:0]  inCode, aluCode;

    always #5 clk = ~clk;

    operand_stage dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
        .rsNum(rsNum), .rtNum(rtNum), .dstNum(dstNum), .imm(imm), .useImm(useImm),
        .inCode(inCode), .wrEnable(wrEnable), .wrNum(wrNum), .wrData(wrData),
        .outValid(outValid), .outReady(outReady), .flush(flush),
        .aluInA(aluInA), .aluInB(aluInB), .aluCode(aluCode), .outDstNum(outDstNum)
    );

    typedef struct {
        logic        iv, ordy, fl, ui;
        logic [4:0]  rs, rt, dst;
        logic [31:0] imm;
        logic [3:0]  code;
        logic        we;
        logic [4:0]  wn;
        logic [31:0] wd;
        logic        chk, ev;
        logic [31:0] ea, eb;
    } vec_t;

`ifdef OPERAND_STAGE_WRITE_BYPASS_EN
    localparam logic [31:0] R7_SAME_EDGE = 32'hAAAA_5555;
`else
    localparam logic [31:0] R7_SAME_EDGE = 32'h0000_0001;
`endif

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model: architectural registers plus the single output slot.
    logic [31:0] m_regs [32];
    logic        m_valid;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_code;
    logic [4:0]  m_dst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_valid = 1'b0; m_a = 32'd0; m_b = 32'd0; m_code = 4'd0; m_dst = 5'd0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        logic [31:0] v;
        v = (idx == 5'd0) ? 32'd0 : m_regs[idx];
`ifdef OPERAND_STAGE_WRITE_BYPASS_EN
        if (wrEnable && wrNum != 5'd0 && wrNum == idx) v = wrData;
`endif
        return v;
    endfunction

    task automatic model_edge();
        logic [31:0] ra, rb;
        logic        can_take;
        ra = model_read(rsNum);
        rb = useImm ? imm : model_read(rtNum);
        can_take = !m_valid || outReady;
        if (flush) m_valid = 1'b0;
        else if (inValid && can_take) begin
            m_valid = 1'b1; m_a = ra; m_b = rb; m_code = inCode; m_dst = dstNum;
        end else if (outReady) m_valid = 1'b0;
        if (wrEnable && wrNum != 5'd0) m_regs[wrNum] = wrData;
    endtask

    task automatic drive(input vec_t v);
        inValid = v.iv; outReady = v.ordy; flush = v.fl; useImm = v.ui;
        rsNum = v.rs; rtNum = v.rt; dstNum = v.dst; imm = v.imm; inCode = v.code;
        wrEnable = v.we; wrNum = v.wn; wrData = v.wd;
    endtask

    // One clock: check inReady before the edge, advance the model, check outputs after.
    task automatic step(input vec_t v, input string tag);
        drive(v);
        #1;
        check({tag, ".inReady"}, {31'd0, inReady}, {31'd0, !m_valid || outReady});
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".outValid"}, {31'd0, outValid}, {31'd0, m_valid});
        if (m_valid) begin
            check({tag, ".aluInA"}, aluInA, m_a);
            check({tag, ".aluInB"}, aluInB, m_b);
            check({tag, ".aluCode"}, {28'd0, aluCode}, {28'd0, m_code});
            check({tag, ".outDstNum"}, {27'd0, outDstNum}, {27'd0, m_dst});
        end
        if (v.chk) begin
            check({tag, ".tbl_valid"}, {31'd0, outValid}, {31'd0, v.ev});
            if (v.ev) begin
                check({tag, ".tbl_a"}, aluInA, v.ea);
                check({tag, ".tbl_b"}, aluInB, v.eb);
            end
        end
    endtask

    function automatic vec_t mk(input logic iv, ordy, fl, ui, input logic [4:0] rs, rt,
                                input logic [31:0] imm_v, input logic [3:0] code,
                                input logic we, input logic [4:0] wn, input logic [31:0] wd,
                                input logic ev, input logic [31:0] ea, eb);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.ui = ui; v.rs = rs; v.rt = rt;
        v.dst = rs ^ 5'd3; v.imm = imm_v; v.code = code; v.we = we; v.wn = wn; v.wd = wd;
        v.chk = 1'b1; v.ev = ev; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    vec_t tbl [14];
    vec_t rv;

    initial begin
        tbl[0]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, ALU_CODE_ADD, 1'b1, 5'd5, 32'h0000_0010, 1'b0, 32'd0, 32'd0);
        tbl[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, ALU_CODE_ADD, 1'b1, 5'd6, 32'h0000_0003, 1'b0, 32'd0, 32'd0);
        tbl[2]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 5'd6, 32'd0, ALU_CODE_SUB, 1'b0, 5'd0, 32'd0, 1'b1, 32'h10, 32'h3);
        tbl[3]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, ALU_CODE_ADD, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 32'd0, 32'd0);
        tbl[4]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 5'd9, 32'hFFFF_FFF0, ALU_CODE_ADD, 1'b0, 5'd0, 32'd0, 1'b1, 32'd0, 32'hFFFF_FFF0);
        tbl[5]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, ALU_CODE_ADD, 1'b1, 5'd7, 32'h0000_0001, 1'b0, 32'd0, 32'd0);
        tbl[6]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 5'd7, 32'd0, ALU_CODE_OR, 1'b1, 5'd7, 32'hAAAA_5555, 1'b1, R7_SAME_EDGE, R7_SAME_EDGE);
        tbl[7]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 5'd0, 32'd0, ALU_CODE_XOR, 1'b0, 5'd0, 32'd0, 1'b1, 32'hAAAA_5555, 32'd0);
        tbl[8]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 5'd6, 32'd0, ALU_CODE_AND, 1'b0, 5'd0, 32'd0, 1'b1, 32'hAAAA_5555, 32'd0);
        tbl[9]  = tbl[8];
        tbl[10] = tbl[8];
        tbl[11] = mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 5'd6, 32'd0, ALU_CODE_AND, 1'b0, 5'd0, 32'd0, 1'b1, 32'h10, 32'h3);
        tbl[12] = mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd6, 5'd6, 32'd0, ALU_CODE_SLT, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        tbl[13] = mk(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, ALU_CODE_ADD, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);

        rst = 1'b1;
        drive(tbl[13]);
        inValid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.outValid", {31'd0, outValid}, 32'd0);
        check("reset.aluInA", aluInA, 32'd0);
        check("reset.aluInB", aluInB, 32'd0);
        check("reset.aluCode", {28'd0, aluCode}, 32'd0);
        check("reset.outDstNum", {27'd0, outDstNum}, 32'd0);
        rst = 1'b0;
        check("reset.inReady", {31'd0, inReady}, 32'd1);

        for (int i = 0; i < 14; i++) step(tbl[i], $sformatf("tbl%0d", i));

        // Reset pulsed while an entry is stalled.
        rv = mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 5'd5, 32'd0, ALU_CODE_SRL, 1'b0, 5'd0, 32'd0, 1'b1, 32'h3, 32'h10);
        step(rv, "pre_rst_accept");
        rv = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 32'd0, ALU_CODE_ADD, 1'b0, 5'd0, 32'd0, 1'b1, 32'h3, 32'h10);
        step(rv, "pre_rst_stall");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("midrst.outValid", {31'd0, outValid}, 32'd0);
        check("midrst.aluInA", aluInA, 32'd0);
        check("midrst.aluInB", aluInB, 32'd0);
        @(posedge clk);
        #1;
        check("midrst.held_valid", {31'd0, outValid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("postrst.inReady", {31'd0, inReady}, 32'd1);
        rv = mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 5'd5, 32'd0, ALU_CODE_ADD, 1'b0, 5'd0, 32'd0, 1'b1, 32'd0, 32'd0);
        step(rv, "postrst_readR5");

        for (int i = 0; i < 400; i++) begin
            rv.iv   = ($urandom_range(0, 3) != 0);
            rv.ordy = ($urandom_range(0, 2) != 0);
            rv.fl   = ($urandom_range(0, 15) == 0);
            rv.ui   = $urandom_range(0, 1);
            rv.rs   = 5'($urandom_range(0, 7));
            rv.rt   = 5'($urandom_range(0, 7));
            rv.dst  = 5'($urandom_range(0, 31));
            rv.imm  = $urandom;
            rv.code = 4'($urandom_range(0, 15));
            rv.we   = $urandom_range(0, 1);
            rv.wn   = 5'($urandom_range(0, 7));
            rv.wd   = $urandom;
            rv.chk  = 1'b0; rv.ev = 1'b0; rv.ea = 32'd0; rv.eb = 32'd0;
            step(rv, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
